// File: rtl/mac_axis_bridge.sv
// MAC external-FIFO write port to AXI4-Stream bridge with packet tracking.
// Damaged packets close with tuser=1 on their tlast beat.
`timescale 1ns/1ps
module mac_axis_bridge #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 16,
   parameter logic [7:0]  TID_VAL   = 8'd0,
   parameter logic [7:0]  TDEST_VAL = 8'd0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_data_start,
   input  logic                     i_data_end,
   input  logic                     i_overflow,
   input  logic                     i_wr,
   output logic [DATA_W-1:0]        axis_tdata,
   output logic [DATA_W/8-1:0]      axis_tkeep,
   output logic [7:0]               axis_tid,
   output logic [7:0]               axis_tdest,
   output logic                     axis_tvalid,
   output logic                     axis_tlast,
   output logic                     axis_tuser,
   input  logic                     axis_tready,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [15:0]              o_drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = DATA_W + 2;

   typedef enum logic {StIdle, StOpen} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_err, w_err_nxt;
   logic          r_term_pend, w_term_pend_nxt;
   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_level;
   logic [15:0]   r_drop_cnt;
   logic          w_valid, w_pop, w_space, w_push, w_drop;
   logic [EW-1:0] w_push_entry, w_head;

   assign w_valid = |r_level;
   assign w_pop   = w_valid & axis_tready;
   // Level can only reach DEPTH, so its MSB alone flags full.
   assign w_space = ~r_level[AW] | w_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_err       <= 1'b0;
         r_term_pend <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_err       <= w_err_nxt;
         r_term_pend <= w_term_pend_nxt;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (!w_push && w_pop) r_level <= r_level - 1'b1;
         if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_push_entry;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_err_nxt       = r_err;
      w_term_pend_nxt = r_term_pend;
      w_push          = 1'b0;
      w_push_entry    = '0;
      w_drop          = 1'b0;
      if (r_term_pend) begin
         // Terminator owns the write slot; any input beat this cycle is lost.
         w_drop = i_wr;
         if (w_space) begin
            w_push          = 1'b1;
            w_push_entry    = {{DATA_W{1'b0}}, 2'b11};
            w_term_pend_nxt = 1'b0;
            w_state_nxt     = StIdle;
            w_err_nxt       = 1'b0;
         end
      end else if (i_wr) begin
         case (r_state)
            StIdle: begin
               if (!i_data_start || !w_space) begin
                  w_drop = 1'b1;
               end else if (i_data_end) begin
                  w_push       = 1'b1;
                  w_push_entry = {i_data, 1'b1, i_overflow};
               end else begin
                  w_push       = 1'b1;
                  w_push_entry = {i_data, 2'b00};
                  w_state_nxt  = StOpen;
                  w_err_nxt    = i_overflow;
               end
            end
            StOpen: begin
               if (i_data_start) begin
                  w_drop          = 1'b1;
                  w_term_pend_nxt = 1'b1;
               end else if (!w_space) begin
                  w_drop = 1'b1;
                  if (i_data_end) w_term_pend_nxt = 1'b1;
                  else            w_err_nxt       = 1'b1;
               end else if (i_data_end) begin
                  w_push       = 1'b1;
                  w_push_entry = {i_data, 1'b1, r_err | i_overflow};
                  w_state_nxt  = StIdle;
                  w_err_nxt    = 1'b0;
               end else begin
                  w_push       = 1'b1;
                  w_push_entry = {i_data, 2'b00};
                  w_err_nxt    = r_err | i_overflow;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end else if (r_state == StOpen && i_overflow) begin
         w_err_nxt = 1'b1;
      end
   end

   always_comb begin
      w_head      = r_mem[r_rptr];
      axis_tvalid = w_valid;
      axis_tdata  = '0;
      axis_tlast  = 1'b0;
      axis_tuser  = 1'b0;
      if (w_valid) begin
         axis_tdata = w_head[EW-1:2];
         axis_tlast = w_head[1];
         axis_tuser = w_head[0];
      end
   end

   assign axis_tkeep = '1;
   assign axis_tid   = TID_VAL;
   assign axis_tdest = TDEST_VAL;
   assign o_level    = r_level;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: doc/mac_axis_bridge.md
# mac_axis_bridge

Parametrised MAC-receive-to-AXI4-Stream bridge that sits between the GEM external-FIFO write interface and downstream AXIS consumers. It buffers beats in an internal FIFO and honours `axis_tready` backpressure. Packets damaged by MAC overflow, local FIFO overflow or a missing end marker are delivered with `axis_tuser=1` on their `axis_tlast` beat. Every closed packet, good or bad, produces exactly one `axis_tlast` beat.

## Interface
Parameters:
- `DATA_W`, 8: data width in bits; must be a multiple of 8.
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `TID_VAL`, 0: constant driven on `axis_tid`.
- `TDEST_VAL`, 0: constant driven on `axis_tdest`.

Ports:
- `clk`  in  1: the design's single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `i_data`  in  DATA_W: MAC write data.
- `i_data_start`  in  1: qualifies the current `i_wr` beat as the first beat of a packet.
- `i_data_end`  in  1: qualifies the current `i_wr` beat as the last beat of a packet.
- `i_overflow`  in  1: MAC overflow; when high in any cycle while a packet is open, the packet is marked bad.
- `i_wr`  in  1: beat write strobe.
- `axis_tdata`  out  DATA_W: FIFO head data.
- `axis_tkeep`  out  DATA_W/8: constant all-ones.
- `axis_tid`  out  8: constant `TID_VAL`.
- `axis_tdest`  out  8: constant `TDEST_VAL`.
- `axis_tvalid`  out  1: FIFO is non-empty.
- `axis_tlast`  out  1: head beat is a packet end.
- `axis_tuser`  out  1: head beat ends a bad packet; only ever high together with `axis_tlast`.
- `axis_tready`  in  1: downstream ready.
- `o_level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `o_drop_cnt`  out  16: saturating count of dropped input beats.

## Operation
- FIFO entry format: {data, last, user}. A pop occurs when `axis_tvalid` and `axis_tready` are both high.
- Push condition: `i_wr=1`, and either `o_level<DEPTH` or a pop happens in the same cycle, and no terminator is pending.
- Packet tracker states:
  - IDLE → OPEN on an accepted `i_wr` beat with `i_data_start`.
  - OPEN → IDLE on a beat with `i_data_end`.
  - A beat with both start and end is a one-beat packet; the state stays IDLE.
- `i_wr` beat while IDLE without `i_data_start` (orphan): dropped, `o_drop_cnt` increments, nothing is pushed.
- Error flag `err` is set while OPEN by any of: `i_overflow=1`, or an `i_wr` beat that cannot be pushed (FIFO full). The rejected beat is dropped and counted.
- `err` is cleared when the packet's last beat is pushed.
- End beat pushed: written with last=1 and user=`err`, including the `i_overflow` of that same cycle.
- End beat that cannot be pushed (FIFO full): set `term_pend`. At the first cycle with space, push a terminator {0, last=1, user=1}, then clear `term_pend` and return to IDLE.
- `i_data_start` beat while OPEN (missing end): the old packet must be closed as bad, so set `term_pend`. The new start beat and all further `i_wr` beats are dropped and counted until the terminator has been pushed.
- `o_drop_cnt` increments by 1 per dropped beat and saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync deassert handled upstream) clears:
  - outputs: `axis_tvalid=0`, `axis_tlast=0`, `axis_tuser=0`, `axis_tdata=0`, `o_level=0`, `o_drop_cnt=0`;
  - internal state: tracker=IDLE, `err=0`, `term_pend=0`, pointers=0.
- Constant outputs (`axis_tkeep`, `axis_tid`, `axis_tdest`) hold their values through reset.
- Latency: a beat pushed in cycle N is visible on the AXIS outputs in cycle N+1, when the FIFO was empty.
- Outputs are driven from registered FIFO state; there is no combinational path from `i_*` to `axis_*`.
- While `axis_tvalid=1` and `axis_tready=0`, `axis_tdata`, `axis_tlast` and `axis_tuser` hold stable.
- Full throughput: one push and one pop per cycle are sustained. Simultaneous push+pop leaves `o_level` unchanged.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- Reset asserted mid-packet discards all FIFO contents with no terminator emitted. After release, the next beat must carry `i_data_start`.

## Test plan
- Back-to-back 64-beat packet, `axis_tready=1`, DEPTH=16: 64 beats out, tlast on beat 64, tuser=0, first tvalid one cycle after first `i_wr`, `o_drop_cnt=0`.
- `axis_tready=0` during a 20-beat packet, DEPTH=16: 16 beats stored, 4 dropped (`o_drop_cnt=4`). End beat dropped → terminator pushed when space frees. After `axis_tready=1`: 16 data beats then {0, last=1, user=1}.
- `i_overflow` pulse on beat 3 of an 8-beat packet: 8 beats out, tuser=1 only on beat 8.
- Start, 5 beats, then a new start with no end: terminator {0, last, user=1} follows beat 5. The new start and following beats are counted as drops until the terminator is pushed.
- Orphan beats with no start, then a 1-beat start+end packet: orphans counted, single beat out with tlast=1, tuser=0.
- Random `axis_tready` toggling with asynchronous `rst` asserted mid-packet: all outputs go to 0 immediately, `o_level=0`, and the scoreboard matches every complete packet before the reset.
